// File: rtl/datapath_controller_pkg.sv
// ctrl_pkg: shared encodings for the accumulator-machine controller.
//   - opcode values of the instruction set (IR bits [15:10])
//   - ALU operation codes driven on alu_operation
//   - mux select encodings for pc, ALU/acc sources, memory data and address
//   - FSM state encoding (3 bits)
// Optional feature macro used elsewhere in this slice: CTRL_MEM_TIMEOUT_EN.
package ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LDI  = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h04;
  localparam logic [5:0] OP_SUB  = 6'h05;
  localparam logic [5:0] OP_AND  = 6'h06;
  localparam logic [5:0] OP_OR   = 6'h07;
  localparam logic [5:0] OP_JMP  = 6'h08;
  localparam logic [5:0] OP_JZ   = 6'h09;
  localparam logic [5:0] OP_JMPA = 6'h0A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  // PC source select
  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_OP1 = 2'd1;
  localparam logic [1:0] PC_SRC_ACC = 2'd2;

  // ALU1/ALU2/ACC source select (0 = acc for ALU inputs, alu_out for acc)
  localparam logic [1:0] SRC_ACC = 2'd0;
  localparam logic [1:0] SRC_OP1 = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  // Memory data bus driver select
  localparam logic [1:0] MDATA_NONE = 2'd0;
  localparam logic [1:0] MDATA_ACC  = 2'd1;
  localparam logic [1:0] MDATA_ALU1 = 2'd2;
  localparam logic [1:0] MDATA_ALU2 = 2'd3;

  // Memory address driver select
  localparam logic [1:0] MADDR_NONE = 2'd0;
  localparam logic [1:0] MADDR_OP1  = 2'd1;
  localparam logic [1:0] MADDR_PC   = 2'd2;
  localparam logic [1:0] MADDR_ACC  = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    OPLOAD = 3'd5,
    EXEC   = 3'd6,
    HALT   = 3'd7
  } state_t;

  // ADD..OR opcodes are contiguous, so the ALU code is the offset from ADD.
  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    logic [5:0] diff;
    diff = op - OP_ADD;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/datapath_controller_if.sv
// datapath_controller_if: bundle between the controller and the datapath.
//   Datapath -> controller: opcode, alu_zero, alu_overflow, mem_ready.
//   Controller -> datapath: register loads, mux selects, ALU op, memory
//   strobes, and status (zero_flag, ovf_flag, halted, fault).
// modport master = controller side, modport slave = datapath side.
interface datapath_controller_if #(
  parameter int INST_SIZE = 6
);

  logic [INST_SIZE-1:0] opcode;
  logic                 alu_zero;
  logic                 alu_overflow;
  logic                 mem_ready;

  logic                 ld_alu1;
  logic                 ld_alu2;
  logic                 ld_pc;
  logic                 ld_acc;
  logic                 ld_ir;
  logic [1:0]           pc_src;
  logic [2:0]           alu_operation;
  logic [1:0]           alu1_src_mux_control;
  logic [1:0]           alu2_src_mux_control;
  logic [1:0]           acc_src_mux_control;
  logic [1:0]           mem_data_select_control;
  logic [1:0]           mem_addr_select_control;
  logic                 mem_read;
  logic                 mem_write;
  logic                 zero_flag;
  logic                 ovf_flag;
  logic                 halted;
  logic                 fault;

  modport master (
    input  opcode, alu_zero, alu_overflow, mem_ready,
    output ld_alu1, ld_alu2, ld_pc, ld_acc, ld_ir, pc_src, alu_operation,
           alu1_src_mux_control, alu2_src_mux_control, acc_src_mux_control,
           mem_data_select_control, mem_addr_select_control,
           mem_read, mem_write, zero_flag, ovf_flag, halted, fault
  );

  modport slave (
    output opcode, alu_zero, alu_overflow, mem_ready,
    input  ld_alu1, ld_alu2, ld_pc, ld_acc, ld_ir, pc_src, alu_operation,
           alu1_src_mux_control, alu2_src_mux_control, acc_src_mux_control,
           mem_data_select_control, mem_addr_select_control,
           mem_read, mem_write, zero_flag, ovf_flag, halted, fault
  );

endinterface

// File: rtl/datapath_controller_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory strobe has been waiting for
// mem_ready and flags expiry once the count reaches MEM_TIMEOUT.
// Present only when CTRL_MEM_TIMEOUT_EN is defined.
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  asynchronous, active-low
//   clear   in  restart the count (not waiting, or memory answered)
//   expired out count has reached MEM_TIMEOUT
`ifdef CTRL_MEM_TIMEOUT_EN
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count_r;

  assign expired = (count_r == CW'(MEM_TIMEOUT));

  // Wait counter: saturates at MEM_TIMEOUT until cleared
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (!expired) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule
`endif

// File: rtl/datapath_controller.sv
// datapath_controller: multi-cycle fetch/decode/execute sequencer for the
// accumulator datapath. One micro-operation per cycle; owns the memory
// read/write handshake (strobes held until mem_ready).
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous, active-low
//   bus    datapath_controller_if.master: opcode/ALU flags/mem_ready in;
//          loads, selects, ALU op, strobes, zero/ovf flags, halted, fault out
// Optional feature: define CTRL_MEM_TIMEOUT_EN to bound every memory wait to
// MEM_TIMEOUT cycles; on expiry the controller halts with fault set.
module datapath_controller
  import ctrl_pkg::*;
#(
  parameter int INST_SIZE     = 6,
  parameter int MEM_ADDR_SIZE = 6,
  parameter int REG_ADDR_SIZE = 4,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  datapath_controller_if.master bus
);

  localparam int WORD_SIZE = INST_SIZE + MEM_ADDR_SIZE + REG_ADDR_SIZE;

  // The opcode decode below assumes the {6,6,4} instruction layout.
  if (WORD_SIZE != 16 || INST_SIZE != 6 || MEM_TIMEOUT < 1) begin : g_cfg_check
    $error("datapath_controller: unsupported instruction layout or timeout");
  end

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] op_s;
  logic       zero_flag_r;
  logic       ovf_flag_r;
  logic       halted_r;
  logic       fault_r;
  logic       set_fault_s;
  logic       timeout_s;

  assign op_s          = bus.opcode[INST_SIZE-1 -: 6];
  assign bus.zero_flag = zero_flag_r;
  assign bus.ovf_flag  = ovf_flag_r;
  assign bus.halted    = halted_r;
  assign bus.fault     = fault_r;

`ifdef CTRL_MEM_TIMEOUT_EN
  logic wait_state_s;

  assign wait_state_s = (state_r == FETCH) || (state_r == MEM_RD) ||
                        (state_r == MEM_WR) || (state_r == OPLOAD);

  // Clearing on every non-wait cycle also clears it on entry to a wait state.
  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!wait_state_s || bus.mem_ready),
    .expired(timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Status registers: ALU flags latch only in EXEC; halt/fault are sticky
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zero_flag_r <= 1'b0;
      ovf_flag_r  <= 1'b0;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      if (state_r == EXEC) begin
        zero_flag_r <= bus.alu_zero;
        ovf_flag_r  <= bus.alu_overflow;
      end else begin
        zero_flag_r <= zero_flag_r;
        ovf_flag_r  <= ovf_flag_r;
      end
      halted_r <= (next_state_s == HALT);
      fault_r  <= fault_r | set_fault_s;
    end
  end

  // Next-state and control decode; every output starts from the idle value
  always_comb begin
    next_state_s                = state_r;
    set_fault_s                 = 1'b0;
    bus.ld_alu1                 = 1'b0;
    bus.ld_alu2                 = 1'b0;
    bus.ld_pc                   = 1'b0;
    bus.ld_acc                  = 1'b0;
    bus.ld_ir                   = 1'b0;
    bus.pc_src                  = PC_SRC_INC;
    bus.alu_operation           = ALU_ADD;
    bus.alu1_src_mux_control    = SRC_ACC;
    bus.alu2_src_mux_control    = SRC_ACC;
    bus.acc_src_mux_control     = SRC_ACC;
    bus.mem_data_select_control = MDATA_NONE;
    bus.mem_addr_select_control = MADDR_NONE;
    bus.mem_read                = 1'b0;
    bus.mem_write               = 1'b0;

    case (state_r)
      IDLE: begin
        next_state_s = FETCH;
      end

      FETCH: begin
        if (timeout_s) begin
          next_state_s = HALT;
          set_fault_s  = 1'b1;
        end else begin
          bus.mem_addr_select_control = MADDR_PC;
          bus.mem_read                = 1'b1;
          if (bus.mem_ready) begin
            bus.ld_ir    = 1'b1;
            bus.ld_pc    = 1'b1;
            bus.pc_src   = PC_SRC_INC;
            next_state_s = DECODE;
          end else begin
            next_state_s = FETCH;
          end
        end
      end

      DECODE: begin
        case (op_s)
          OP_NOP: begin
            next_state_s = FETCH;
          end
          OP_LDI: begin
            bus.acc_src_mux_control = SRC_OP1;
            bus.ld_acc              = 1'b1;
            next_state_s            = FETCH;
          end
          OP_LD: begin
            next_state_s = MEM_RD;
          end
          OP_ST: begin
            next_state_s = MEM_WR;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            next_state_s = OPLOAD;
          end
          OP_JMP: begin
            bus.pc_src   = PC_SRC_OP1;
            bus.ld_pc    = 1'b1;
            next_state_s = FETCH;
          end
          OP_JZ: begin
            bus.pc_src   = PC_SRC_OP1;
            bus.ld_pc    = zero_flag_r;
            next_state_s = FETCH;
          end
          OP_JMPA: begin
            bus.pc_src   = PC_SRC_ACC;
            bus.ld_pc    = 1'b1;
            next_state_s = FETCH;
          end
          OP_HALT: begin
            next_state_s = HALT;
          end
          default: begin
            next_state_s = HALT;
            set_fault_s  = 1'b1;
          end
        endcase
      end

      MEM_RD: begin
        if (timeout_s) begin
          next_state_s = HALT;
          set_fault_s  = 1'b1;
        end else begin
          bus.mem_addr_select_control = MADDR_OP1;
          bus.mem_read                = 1'b1;
          bus.acc_src_mux_control     = SRC_MEM;
          bus.ld_acc                  = bus.mem_ready;
          next_state_s                = bus.mem_ready ? FETCH : MEM_RD;
        end
      end

      MEM_WR: begin
        if (timeout_s) begin
          next_state_s = HALT;
          set_fault_s  = 1'b1;
        end else begin
          bus.mem_addr_select_control = MADDR_OP1;
          bus.mem_data_select_control = MDATA_ACC;
          bus.mem_write               = 1'b1;
          next_state_s                = bus.mem_ready ? FETCH : MEM_WR;
        end
      end

      OPLOAD: begin
        if (timeout_s) begin
          next_state_s = HALT;
          set_fault_s  = 1'b1;
        end else begin
          bus.mem_addr_select_control = MADDR_OP1;
          bus.mem_read                = 1'b1;
          bus.alu1_src_mux_control    = SRC_ACC;
          bus.alu2_src_mux_control    = SRC_MEM;
          bus.ld_alu1                 = bus.mem_ready;
          bus.ld_alu2                 = bus.mem_ready;
          next_state_s                = bus.mem_ready ? EXEC : OPLOAD;
        end
      end

      EXEC: begin
        bus.alu_operation       = alu_op_of(op_s);
        bus.acc_src_mux_control = SRC_ACC;
        bus.ld_acc              = 1'b1;
        next_state_s            = FETCH;
      end

      HALT: begin
        next_state_s = HALT;
      end

      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
module tb_datapath_controller;
  import ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  datapath_controller_if #(.INST_SIZE(6)) bus ();

  datapath_controller #(
    .INST_SIZE(6), .MEM_ADDR_SIZE(6), .REG_ADDR_SIZE(4), .MEM_TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- datapath + memory environment ----------------
  logic [15:0] img [64];
  logic [15:0] mem [64];
  logic [3:0]  plan [16];
  logic        rand_mode = 1'b0;
  logic        stuck = 1'b0;
  logic [5:0]  pc;
  logic [15:0] ir, acc, alu1, alu2, alu_out, rdata, wdata;
  logic        alu_v;
  logic [5:0]  addr;
  logic [3:0]  wait_cnt, wait_target;
  int          plan_idx;
  int          total_waits;
  logic [4:0]  loads;

  assign loads = {bus.ld_alu1, bus.ld_alu2, bus.ld_pc, bus.ld_acc, bus.ld_ir};
  assign bus.opcode = ir[15:10];
  assign bus.alu_zero = (alu_out == 16'h0000);
  assign bus.alu_overflow = alu_v;
  assign bus.mem_ready = (bus.mem_read | bus.mem_write) & ~stuck & (wait_cnt >= wait_target);

  always_comb begin
    case (bus.mem_addr_select_control)
      2'd1: addr = ir[9:4];
      2'd2: addr = pc;
      2'd3: addr = acc[5:0];
      default: addr = 6'd0;
    endcase
    rdata = mem[addr];
    case (bus.mem_data_select_control)
      2'd1: wdata = acc;
      2'd2: wdata = alu1;
      2'd3: wdata = alu2;
      default: wdata = 16'h0000;
    endcase
    alu_v = 1'b0;
    case (bus.alu_operation)
      3'd0: begin alu_out = alu1 + alu2; alu_v = (alu1[15] == alu2[15]) && (alu_out[15] != alu1[15]); end
      3'd1: begin alu_out = alu1 - alu2; alu_v = (alu1[15] != alu2[15]) && (alu_out[15] != alu1[15]); end
      3'd2: alu_out = alu1 & alu2;
      3'd3: alu_out = alu1 | alu2;
      3'd4: alu_out = alu1 ^ alu2;
      3'd5: alu_out = ~alu1;
      3'd6: alu_out = alu1 << 1;
      default: alu_out = alu1 >> 1;
    endcase
  end

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] zero_src);
    case (sel)
      2'd1: return {10'd0, ir[9:4]};
      2'd2: return rdata;
      default: return zero_src;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
      pc <= 6'd0; ir <= 16'h0000; acc <= 16'h0000; alu1 <= 16'h0000; alu2 <= 16'h0000;
      wait_cnt <= 4'd0; total_waits <= 0; plan_idx <= 1;
      wait_target <= rand_mode ? 4'($urandom_range(0, 3)) : plan[0];
    end else begin
      if (bus.ld_ir) ir <= rdata;
      if (bus.ld_pc) pc <= (bus.pc_src == 2'd1) ? ir[9:4] : (bus.pc_src == 2'd2) ? acc[5:0] : pc + 6'd1;
      if (bus.ld_acc) acc <= pick(bus.acc_src_mux_control, alu_out);
      if (bus.ld_alu1) alu1 <= pick(bus.alu1_src_mux_control, acc);
      if (bus.ld_alu2) alu2 <= pick(bus.alu2_src_mux_control, acc);
      if (bus.mem_write && bus.mem_ready) mem[addr] <= wdata;
      if (bus.mem_read || bus.mem_write) begin
        if (bus.mem_ready) begin
          wait_cnt <= 4'd0;
          wait_target <= rand_mode ? 4'($urandom_range(0, 3)) : plan[plan_idx[3:0]];
          plan_idx <= plan_idx + 1;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
          total_waits <= total_waits + 1;
        end
      end
    end
  end

  // ---------------- instruction-level reference ----------------
  logic [15:0] ref_mem [64];
  logic [15:0] ref_acc;
  logic        ref_z, ref_v, ref_fault;
  int          ref_cost;

  task automatic ref_run();
    logic [5:0] rpc, a;
    logic [15:0] w, m, r;
    bit done;
    ref_mem = img; rpc = 6'd0; ref_acc = 16'h0000; ref_z = 1'b0; ref_v = 1'b0;
    ref_fault = 1'b0; ref_cost = 1; done = 1'b0;
    for (int s = 0; s < 300 && !done; s++) begin
      w = ref_mem[rpc]; a = w[9:4]; m = ref_mem[a];
      rpc = rpc + 6'd1;
      case (w[15:10])
        6'h00: ref_cost += 2;
        6'h01: begin ref_acc = {10'd0, a}; ref_cost += 2; end
        6'h02: begin ref_acc = m; ref_cost += 3; end
        6'h03: begin ref_mem[a] = ref_acc; ref_cost += 3; end
        6'h04, 6'h05, 6'h06, 6'h07: begin
          ref_v = 1'b0;
          case (w[15:10])
            6'h04: begin r = ref_acc + m; ref_v = (ref_acc[15] == m[15]) && (r[15] != ref_acc[15]); end
            6'h05: begin r = ref_acc - m; ref_v = (ref_acc[15] != m[15]) && (r[15] != ref_acc[15]); end
            6'h06: r = ref_acc & m;
            default: r = ref_acc | m;
          endcase
          ref_acc = r; ref_z = (r == 16'h0000); ref_cost += 4;
        end
        6'h08: begin rpc = a; ref_cost += 2; end
        6'h09: begin if (ref_z) rpc = a; ref_cost += 2; end
        6'h0A: begin rpc = ref_acc[5:0]; ref_cost += 2; end
        6'h3F: begin ref_cost += 2; done = 1'b1; end
        default: begin ref_cost += 2; ref_fault = 1'b1; done = 1'b1; end
      endcase
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] ld, input logic [1:0] maddr,
                      input logic rd, input logic wr);
    @(negedge clock);
    chk({tag, "_loads"}, 32'(loads), 32'(ld));
    chk({tag, "_maddr"}, 32'(bus.mem_addr_select_control), 32'(maddr));
    chk({tag, "_rd"}, 32'(bus.mem_read), 32'(rd));
    chk({tag, "_wr"}, 32'(bus.mem_write), 32'(wr));
  endtask

  task automatic run_prog(input string tag);
    int cyc;
    int bad;
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    ref_run();
    cyc = 0;
    while (bus.halted !== 1'b1 && cyc < 3000) begin
      @(negedge clock); cyc++;
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, "_halted"}, 32'(bus.halted), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(ref_cost + total_waits));
    chk({tag, "_acc"}, 32'(acc), 32'(ref_acc));
    chk({tag, "_zero"}, 32'(bus.zero_flag), 32'(ref_z));
    chk({tag, "_ovf"}, 32'(bus.ovf_flag), 32'(ref_v));
    chk({tag, "_fault"}, 32'(bus.fault), 32'(ref_fault));
    chk({tag, "_mem"}, 32'(bad), 32'd0);
  endtask

  task automatic gen_prog();
    int k;
    logic [5:0] a;
    for (int i = 0; i < 64; i++) img[i] = 16'hFC00;
    for (int i = 40; i < 64; i++) img[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 9);
      if (k >= 8) a = 6'($urandom_range(i + 1, 24));
      else if (k >= 2) a = 6'($urandom_range(40, 63));
      else a = 6'($urandom_range(0, 63));
      img[i] = {6'(k), a, 4'($urandom_range(0, 15))};
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) img[i] = 16'h0000;
    img[0] = 16'h0450; img[1] = 16'h08A0; img[2] = 16'h14B0; img[3] = 16'h2600;
    img[32] = 16'h0CC0; img[33] = 16'h5400;
    img[10] = 16'h1234; img[11] = 16'h1234; img[12] = 16'hBEEF;
    for (int i = 0; i < 16; i++) plan[i] = 4'd0;
    plan[2] = 4'd3; plan[7] = 4'd2;

    #2 reset = 1'b0;
    #1;
    chk("rst_loads", 32'(loads), 32'd0);
    chk("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("rst_status", 32'({bus.zero_flag, bus.ovf_flag, bus.halted, bus.fault}), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle_rd", 32'(bus.mem_read), 32'd0);

    step("fetch0", 5'b00101, 2'd2, 1'b1, 1'b0);
    chk("fetch0_pcsrc", 32'(bus.pc_src), 32'd0);
    step("ldi_dec", 5'b00010, 2'd0, 1'b0, 1'b0);
    chk("ldi_accsrc", 32'(bus.acc_src_mux_control), 32'd1);
    step("fetch1", 5'b00101, 2'd2, 1'b1, 1'b0);
    chk("fetch1_pc", 32'(pc), 32'd1);
    chk("ldi_acc", 32'(acc), 32'd5);
    step("ld_dec", 5'b00000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step("ld_wait", (k == 3) ? 5'b00010 : 5'b00000, 2'd1, 1'b1, 1'b0);
      chk("ld_accsrc", 32'(bus.acc_src_mux_control), 32'd2);
    end
    step("fetch2", 5'b00101, 2'd2, 1'b1, 1'b0);
    chk("ld_acc", 32'(acc), 32'h1234);
    step("sub_dec", 5'b00000, 2'd0, 1'b0, 1'b0);
    step("opload", 5'b11000, 2'd1, 1'b1, 1'b0);
    chk("opload_srcs", 32'({bus.alu1_src_mux_control, bus.alu2_src_mux_control}), 32'h2);
    step("exec", 5'b00010, 2'd0, 1'b0, 1'b0);
    chk("exec_aluop", 32'(bus.alu_operation), 32'd1);
    chk("exec_accsrc", 32'(bus.acc_src_mux_control), 32'd0);
    step("fetch3", 5'b00101, 2'd2, 1'b1, 1'b0);
    chk("sub_zero", 32'(bus.zero_flag), 32'd1);
    step("jz_dec", 5'b00100, 2'd0, 1'b0, 1'b0);
    chk("jz_pcsrc", 32'(bus.pc_src), 32'd1);
    step("fetch32", 5'b00101, 2'd2, 1'b1, 1'b0);
    chk("jz_pc", 32'(pc), 32'h20);
    step("st_dec", 5'b00000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("st_wait", 5'b00000, 2'd1, 1'b0, 1'b1);
      chk("st_mdata", 32'(bus.mem_data_select_control), 32'd1);
    end
    step("fetch33", 5'b00101, 2'd2, 1'b1, 1'b0);
    chk("st_mem", 32'(mem[12]), 32'h0000);
    step("ill_dec", 5'b00000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step("halt_idle", 5'b00000, 2'd0, 1'b0, 1'b0);
      chk("halt_status", 32'({bus.halted, bus.fault}), 32'h3);
    end
    reset = 1'b0;
    #1;
    chk("rst_clear", 32'({bus.halted, bus.fault}), 32'd0);

    // memory never answers
    stuck = 1'b1;
    for (int i = 0; i < 64; i++) img[i] = 16'hFC00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
`ifdef CTRL_MEM_TIMEOUT_EN
    cyc = 0;
    while (bus.halted !== 1'b1 && cyc < 50) begin
      @(negedge clock); cyc++;
    end
    chk("tmo_cycles", 32'(cyc), 32'(1 + 4 + 1));
    chk("tmo_status", 32'({bus.halted, bus.fault, bus.mem_read}), 32'h6);
`else
    repeat (100) @(negedge clock);
    chk("notmo_rd", 32'(bus.mem_read), 32'd1);
    chk("notmo_maddr", 32'(bus.mem_addr_select_control), 32'd2);
    chk("notmo_status", 32'({bus.halted, bus.fault}), 32'd0);
`endif
    stuck = 1'b0;

    // JMPA through acc, with random memory latency
    rand_mode = 1'b1;
    for (int i = 0; i < 64; i++) img[i] = 16'h5400;
    img[0] = 16'h05E0; img[1] = 16'h2800; img[30] = 16'hFC00;
    run_prog("jmpa");

    for (int p = 0; p < 4; p++) begin
      gen_prog();
      run_prog($sformatf("rand%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
